// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: datapath widths, PC step and the fetch-queue entry layout.
package riscv_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0]    PC_STEP   = 32'd4;

   // One fetched instruction together with the address it came from.
   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions with flush and registered head outputs.
module fetch_queue
   import riscv_pkg::*;
#(
   parameter int unsigned QDEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  fetch_entry_t                push_entry,
   input  logic                        pop,
   input  logic                        flush,
   output logic                        head_valid,
   output fetch_entry_t                head_entry,
   output logic [$clog2(QDEPTH):0]     count
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;

   fetch_entry_t    mem_q [QDEPTH];
   logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            valid_q, valid_d;
   fetch_entry_t    head_q, head_d;
   logic            do_push, do_pop;

   // A flush discards everything, including a push offered in the same cycle.
   assign do_push = push & ~flush;
   assign do_pop  = pop & (count_q != '0) & ~flush;

   // Next pointer/count state and the head that will be visible after the edge.
   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + 1'b1;
         if (do_pop)  rd_d = rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
      valid_d = (count_d != '0);
      // The new head is the entry being written only when it lands exactly at the read slot.
      if (!valid_d) begin
         head_d = '0;
      end else if (do_push && (wr_q == rd_d)) begin
         head_d = push_entry;
      end else begin
         head_d = mem_q[rd_d];
      end
   end

   // Entry storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_entry;
   end

   // Pointer, count and registered head state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         head_q  <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         valid_q <= valid_d;
         head_q  <= head_d;
      end
   end

   assign head_valid = valid_q;
   assign head_entry = head_q;
   assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the pc, reads a zero-latency imem and queues words for decode.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned QDEPTH     = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fetch_oob
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;
   // One bit wider than the pc so the byte limit cannot overflow.
   localparam logic [XLEN:0] IMEM_LIMIT = (XLEN+1)'(IMEM_WORDS) << 2;

   logic [XLEN-1:0] pc_q, pc_d;
   logic            oob_q, oob_d;
   logic [CW-1:0]   count;
   logic            deq, in_range, can_push, fetch;
   fetch_entry_t    push_entry, head_entry;
   logic            unused_redirect_lsb;

   assign deq       = out_valid & out_ready;
   assign in_range  = ({1'b0, pc_q} < IMEM_LIMIT);
   assign can_push  = (count < CW'(QDEPTH)) | deq;
   assign fetch     = ~redirect_valid & ~oob_q & in_range & can_push;

   assign imem_addr        = pc_q;
   assign push_entry.pc    = pc_q;
   assign push_entry.instr = imem_rdata;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Redirect beats everything; otherwise advance on fetch or latch the out-of-range halt.
   always_comb begin
      pc_d  = pc_q;
      oob_d = oob_q;
      if (redirect_valid) begin
         pc_d  = {redirect_pc[31:2], 2'b00};
         oob_d = 1'b0;
      end else if (fetch) begin
         pc_d = pc_q + PC_STEP;
      end else if (!in_range) begin
         oob_d = 1'b1;
      end
   end

   // Program counter and sticky out-of-range flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         oob_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         oob_q <= oob_d;
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (fetch),
      .push_entry (push_entry),
      .pop        (deq),
      .flush      (redirect_valid),
      .head_valid (out_valid),
      .head_entry (head_entry),
      .count      (count)
   );

   assign out_instr = head_entry.instr;
   assign out_pc    = head_entry.pc;
   assign fetch_oob = oob_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory; owns the program counter and drives the memory's combinational read address.
- Captures the returned word plus its PC into a small fetch queue, then presents it to decode with a valid/ready handshake.
- Handles control-flow redirects (branch/jump) with a queue flush.
- Stops fetching when the PC leaves the populated memory range.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 64, number of words in instruction memory; fetch range is [0, IMEM_WORDS*4).
- QDEPTH, 2, fetch-queue entries (power of two, >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory, always equal to the current pc.
- imem_rdata  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  one-cycle pulse; a redirect is requested this cycle.
- redirect_pc  in  32  redirect target (byte address).
- out_valid  out  1  queue head valid toward decode.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  instruction at queue head.
- out_pc  out  32  PC of the queue-head instruction.
- fetch_oob  out  1  sticky flag: fetch halted because pc is out of range.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; queue empty (count=0, rd/wr pointers 0).
  - out_valid=0, out_instr=0, out_pc=0, fetch_oob=0.
  - Release is synchronous to the next rising clk.
- imem_addr = pc, combinational from the pc register; the memory's read latency is 0 cycles.
- Signal definitions:
  - deq = out_valid & out_ready.
  - in_range = (pc < IMEM_WORDS*4).
  - can_push = (count < QDEPTH) | deq.
  - fetch = ~redirect_valid & ~fetch_oob & in_range & can_push.
- On fetch: push {pc, imem_rdata} at wr pointer; pc <= pc + 4. Push and pop in the same cycle keep count unchanged, including when the queue is full.
- Throughput: 1 instruction per cycle when decode is always ready. First out_valid appears 1 cycle after reset release.
- Head outputs:
  - out_valid = (count != 0); out_instr/out_pc show the entry at rd pointer.
  - When empty, out_instr and out_pc are 0.
  - Head outputs are registered; they must be stable while out_valid=1 and out_ready=0.
- Redirect has top priority:
  - In a redirect cycle: queue flushed (count=0, pointers 0), no push, pc <= {redirect_pc[31:2], 2'b00}, fetch_oob <= 0.
  - A head accepted in the same cycle (deq=1) counts as consumed; it is not re-presented.
  - out_valid=0 in the cycle after a redirect; the target instruction appears 1 cycle later (redirect-to-valid latency = 2 edges).
- Out-of-range:
  - When ~in_range and no redirect: fetch_oob <= 1, pc holds, nothing pushed.
  - Queued entries still drain normally.
  - Only a redirect (or reset) clears fetch_oob.
- pc arithmetic is modulo 2^32. At 32'hFFFF_FFFC the next pc is 0, though in practice in_range blocks this first.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are discarded.
- Queue pointers are log2(QDEPTH) bits and wrap naturally; count is log2(QDEPTH)+1 bits.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN=32, INSTR_W=32, NOP_INSTR=32'h0000_0013, PC_STEP=4.
  - Typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_queue:
  - Parameterised QDEPTH-entry synchronous FIFO with push/pop/flush, count, and registered head outputs.
  - fetch_unit instantiates it beside the pc register and fetch-control logic.

Test Plan:
- Reset then out_ready=1 with memory words 0..3 = W0..W3:
  - out_pc sequence 0,4,8,12 on consecutive cycles; out_instr = W0..W3; imem_addr leads out_pc by one cycle.
- Backpressure: out_ready=0 for 5 cycles after the first valid:
  - Queue fills to 2 (heads pc 0); pc stops at 8 and holds.
  - out_instr stable; on out_ready=1, pcs 0,4,8 delivered in order with no loss or duplicate.
- Redirect:
  - Pulse redirect_valid with redirect_pc=32'h0000_0022 while the queue holds 2 entries.
  - Next cycle out_valid=0, pc=32'h20; following cycle out_pc=32'h20, out_instr=word 8.
- Redirect coincident with deq: flushed head not re-presented; no entry from the old stream appears after the redirect.
- Out-of-range, IMEM_WORDS=4:
  - After pc reaches 16, fetch_oob=1 and imem_addr holds at 16.
  - Entries for pc 0..12 drain; redirect to 0 clears fetch_oob and restarts from pc 0.
- Async reset asserted mid-stream between clock edges:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release the stream restarts at RESET_PC.
